// File: rtl/npc_sim_pkg.sv
// rtl/npc_sim_pkg.sv - shared types and constants for the npc simulation monitors
package npc_sim_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        RSN_NONE   = 2'd0,
        RSN_EBREAK = 2'd1,
        RSN_WDT    = 2'd2,
        RSN_ZERO   = 2'd3
    } reason_e;

    localparam logic [31:0] EBREAK_ENC    = 32'h0010_0073;
    localparam logic [63:0] EXIT_ALL_ONES = '1;

endpackage

// File: rtl/npc_sat_counter.sv
// rtl/npc_sat_counter.sv - up counter with enable, synchronous clear and optional saturation
module npc_sat_counter #(
    parameter int W        = 8,
    parameter bit SATURATE = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !(SATURATE && (&cnt_q))) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/npc_trap_monitor.sv
// rtl/npc_trap_monitor.sv - detects ebreak / zero instruction / stalled core and latches a halt record
module npc_trap_monitor
    import npc_sim_pkg::*;
#(
    parameter int          XLEN         = 32,
    parameter int          CNT_W        = 64,
    parameter logic [31:0] EBREAK_INST  = EBREAK_ENC,
    parameter int          DRAIN_CYCLES = 2,
    parameter int          WDT_LIMIT    = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inst_valid,
    input  logic [31:0]      inst,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  a0,
    output logic             halt,
    output logic             halt_pulse,
    output logic [1:0]       halt_reason,
    output logic [XLEN-1:0]  halt_code,
    output logic [XLEN-1:0]  trap_pc,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] inst_cnt
);

    localparam int DRAIN_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int DRAIN_LAST_I = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_LAST_I[DRAIN_W-1:0];
    localparam int WDT_W        = (WDT_LIMIT > 1) ? $clog2(WDT_LIMIT) : 1;
    localparam int WDT_LAST_I   = (WDT_LIMIT > 0) ? WDT_LIMIT - 1 : 0;
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_LAST_I[WDT_W-1:0];
    localparam logic [XLEN-1:0] CODE_ONES = EXIT_ALL_ONES[XLEN-1:0];

    state_e             state_q, state_d;
    reason_e            reason_q, reason_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic               halt_q, halt_d;
    logic               pulse_q, pulse_d;
    logic [XLEN-1:0]    code_q, code_d;
    logic [XLEN-1:0]    trap_pc_q, trap_pc_d;
    logic [XLEN-1:0]    last_pc_q, last_pc_d;
    logic [WDT_W-1:0]   wdt_cnt;
    logic               running, is_ebreak, is_zero, wdt_fire;

    assign running   = (state_q != ST_HALTED);
    assign is_ebreak = inst_valid && (inst == EBREAK_INST);
    assign is_zero   = inst_valid && (inst == 32'd0);
    assign wdt_fire  = (WDT_LIMIT != 0) && !inst_valid && (wdt_cnt == WDT_LAST);

    npc_sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk(clk), .rst_n(rst), .en(running), .clr(1'b0), .cnt(cycle_cnt)
    );

    npc_sat_counter #(.W(CNT_W)) u_inst_cnt (
        .clk(clk), .rst_n(rst), .en(running && inst_valid), .clr(1'b0), .cnt(inst_cnt)
    );

    // Any retirement restarts the stall window; a zero limit pins it at 0.
    npc_sat_counter #(.W(WDT_W)) u_wdt_cnt (
        .clk  (clk),
        .rst_n(rst),
        .en   ((state_q == ST_RUN) && !inst_valid && (WDT_LIMIT != 0)),
        .clr  (inst_valid || (WDT_LIMIT == 0)),
        .cnt  (wdt_cnt)
    );

    always_comb begin
        state_d   = state_q;
        reason_d  = reason_q;
        drain_d   = drain_q;
        halt_d    = halt_q;
        pulse_d   = 1'b0;
        code_d    = code_q;
        trap_pc_d = trap_pc_q;
        last_pc_d = (inst_valid && running) ? pc : last_pc_q;
        case (state_q)
            ST_RUN: begin
                if (is_ebreak) begin
                    trap_pc_d = pc;
                    reason_d  = RSN_EBREAK;
                    if (DRAIN_CYCLES == 0) begin
                        code_d  = a0;
                        state_d = ST_HALTED;
                        halt_d  = 1'b1;
                        pulse_d = 1'b1;
                    end else begin
                        drain_d = DRAIN_LAST;
                        state_d = ST_DRAIN;
                    end
                end else if (is_zero || wdt_fire) begin
                    reason_d  = is_zero ? RSN_ZERO : RSN_WDT;
                    trap_pc_d = is_zero ? pc : last_pc_q;
                    code_d    = CODE_ONES;
                    state_d   = ST_HALTED;
                    halt_d    = 1'b1;
                    pulse_d   = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    code_d  = a0;
                    state_d = ST_HALTED;
                    halt_d  = 1'b1;
                    pulse_d = 1'b1;
                end else begin
                    drain_d = drain_q - DRAIN_W'(1);
                end
            end
            ST_HALTED: ;
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_RUN;
            reason_q  <= RSN_NONE;
            drain_q   <= '0;
            halt_q    <= 1'b0;
            pulse_q   <= 1'b0;
            code_q    <= '0;
            trap_pc_q <= '0;
            last_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            reason_q  <= reason_d;
            drain_q   <= drain_d;
            halt_q    <= halt_d;
            pulse_q   <= pulse_d;
            code_q    <= code_d;
            trap_pc_q <= trap_pc_d;
            last_pc_q <= last_pc_d;
        end
    end

    assign halt        = halt_q;
    assign halt_pulse  = pulse_q;
    assign halt_reason = reason_q;
    assign halt_code   = code_q;
    assign trap_pc     = trap_pc_q;

endmodule

// File: tb/tb_npc_trap_monitor.sv
// tb/tb_npc_trap_monitor.sv - directed vector bench for npc_trap_monitor
module tb_npc_trap_monitor;

    localparam logic [31:0] EBRK = 32'h0010_0073;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inst_valid = 1'b0;
    logic [31:0] inst = '0;
    logic [31:0] pc = '0;
    logic [31:0] a0 = '0;

    logic        a_halt, a_pulse;
    logic [1:0]  a_reason;
    logic [31:0] a_code, a_tpc;
    logic [63:0] a_cyc, a_icnt;
    logic        b_halt, b_pulse;
    logic [1:0]  b_reason;
    logic [31:0] b_code, b_tpc;
    logic [3:0]  b_cyc, b_icnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    npc_trap_monitor #(.XLEN(32), .CNT_W(64), .DRAIN_CYCLES(2), .WDT_LIMIT(16)) dut_a (
        .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst(inst), .pc(pc), .a0(a0),
        .halt(a_halt), .halt_pulse(a_pulse), .halt_reason(a_reason), .halt_code(a_code),
        .trap_pc(a_tpc), .cycle_cnt(a_cyc), .inst_cnt(a_icnt)
    );

    npc_trap_monitor #(.XLEN(32), .CNT_W(4), .DRAIN_CYCLES(0), .WDT_LIMIT(0)) dut_b (
        .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst(inst), .pc(pc), .a0(a0),
        .halt(b_halt), .halt_pulse(b_pulse), .halt_reason(b_reason), .halt_code(b_code),
        .trap_pc(b_tpc), .cycle_cnt(b_cyc), .inst_cnt(b_icnt)
    );

    typedef struct {
        logic        v;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] a0;
        logic        e_halt;
        logic        e_pulse;
        logic [63:0] e_icnt;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] i, input logic [31:0] p, input logic [31:0] a);
        inst_valid = v;
        inst       = i;
        pc         = p;
        a0         = a;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        inst_valid = 1'b0;
        inst       = '0;
        pc         = '0;
        a0         = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        tbl[0] = '{1'b1, NOP,  32'h8000_0000, 32'd0, 1'b0, 1'b0, 64'd1};
        tbl[1] = '{1'b1, NOP,  32'h8000_0004, 32'd0, 1'b0, 1'b0, 64'd2};
        tbl[2] = '{1'b1, NOP,  32'h8000_0008, 32'd0, 1'b0, 1'b0, 64'd3};
        tbl[3] = '{1'b1, NOP,  32'h8000_000C, 32'd0, 1'b0, 1'b0, 64'd4};
        tbl[4] = '{1'b1, NOP,  32'h8000_0010, 32'd0, 1'b0, 1'b0, 64'd5};
        tbl[5] = '{1'b1, EBRK, 32'h8000_0014, 32'd0, 1'b0, 1'b0, 64'd6};
        tbl[6] = '{1'b0, 32'd0, 32'd0,        32'd0, 1'b0, 1'b0, 64'd6};
        tbl[7] = '{1'b0, 32'd0, 32'd0,        32'd0, 1'b1, 1'b1, 64'd6};
        tbl[8] = '{1'b0, 32'd0, 32'd0,        32'd0, 1'b1, 1'b0, 64'd6};

        // Reset state
        do_reset();
        chk("rst_halt", a_halt, 0);
        chk("rst_pulse", a_pulse, 0);
        chk("rst_reason", a_reason, 0);
        chk("rst_code", a_code, 0);
        chk("rst_tpc", a_tpc, 0);
        chk("rst_cyc", a_cyc, 0);
        chk("rst_icnt", a_icnt, 0);

        // Ebreak after five instructions, two drain cycles
        for (int k = 0; k < 9; k++) begin
            step(tbl[k].v, tbl[k].inst, tbl[k].pc, tbl[k].a0);
            chk($sformatf("tbl%0d_halt", k), a_halt, tbl[k].e_halt);
            chk($sformatf("tbl%0d_pulse", k), a_pulse, tbl[k].e_pulse);
            chk($sformatf("tbl%0d_icnt", k), a_icnt, tbl[k].e_icnt);
        end
        chk("eb_reason", a_reason, 1);
        chk("eb_code", a_code, 0);
        chk("eb_tpc", a_tpc, 32'h8000_0014);
        chk("eb_cyc", a_cyc, 8);
        chk("b_eb_halt", b_halt, 1);
        chk("b_eb_reason", b_reason, 1);
        chk("b_eb_tpc", b_tpc, 32'h8000_0014);
        chk("b_eb_icnt", b_icnt, 6);
        chk("b_eb_cyc", b_cyc, 6);
        for (int k = 0; k < 10; k++) step(1'b1, NOP, 32'h8000_0100, 32'd9);
        chk("frz_cyc", a_cyc, 8);
        chk("frz_icnt", a_icnt, 6);
        chk("frz_code", a_code, 0);
        chk("frz_halt", a_halt, 1);
        chk("frz_pulse", a_pulse, 0);
        chk("b_frz_cyc", b_cyc, 6);

        // a0 sampled at end of drain, and at detection when there is no drain
        do_reset();
        step(1'b1, EBRK, 32'h8000_0020, 32'd5);
        chk("b_nodrain_halt", b_halt, 1);
        chk("b_nodrain_code", b_code, 5);
        step(1'b1, NOP, 32'h8000_0024, 32'h2A);
        chk("drn_a0_nohalt", a_halt, 0);
        step(1'b0, 32'd0, 32'd0, 32'h2A);
        chk("drn_a0_halt", a_halt, 1);
        chk("drn_a0_code", a_code, 32'h2A);
        chk("drn_a0_tpc", a_tpc, 32'h8000_0020);
        chk("drn_icnt", a_icnt, 2);

        // Watchdog after 16 idle cycles; disabled watchdog never fires
        do_reset();
        step(1'b1, NOP, 32'h8000_0100, 32'd3);
        for (int k = 0; k < 15; k++) step(1'b0, 32'd0, 32'd0, 32'd3);
        chk("wdt_15_nohalt", a_halt, 0);
        step(1'b0, 32'd0, 32'd0, 32'd3);
        chk("wdt_16_halt", a_halt, 1);
        chk("wdt_pulse", a_pulse, 1);
        chk("wdt_reason", a_reason, 2);
        chk("wdt_code", a_code, ONES);
        chk("wdt_tpc", a_tpc, 32'h8000_0100);
        chk("wdt_cyc", a_cyc, 17);
        chk("b_sat_cyc", b_cyc, 15);
        chk("b_icnt", b_icnt, 1);
        for (int k = 0; k < 100; k++) step(1'b0, 32'd0, 32'd0, 32'd3);
        chk("b_wdt_off_halt", b_halt, 0);
        chk("b_wdt_off_reason", b_reason, 0);
        chk("b_sat_cyc_hold", b_cyc, 15);
        chk("wdt_frz_cyc", a_cyc, 17);

        // Zero instruction
        do_reset();
        step(1'b1, 32'd0, 32'h8000_0040, 32'd1);
        chk("zero_halt", a_halt, 1);
        chk("zero_pulse", a_pulse, 1);
        chk("zero_reason", a_reason, 3);
        chk("zero_code", a_code, ONES);
        chk("zero_tpc", a_tpc, 32'h8000_0040);
        chk("zero_icnt", a_icnt, 1);
        chk("b_zero_reason", b_reason, 3);

        // Asynchronous reset during drain, then a normal ebreak
        do_reset();
        step(1'b1, EBRK, 32'h8000_0050, 32'd4);
        step(1'b0, 32'd0, 32'd0, 32'd4);
        rst = 1'b0;
        #1;
        chk("arst_halt", a_halt, 0);
        chk("arst_pulse", a_pulse, 0);
        chk("arst_reason", a_reason, 0);
        chk("arst_tpc", a_tpc, 0);
        chk("arst_cyc", a_cyc, 0);
        chk("arst_icnt", a_icnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 32'd0, 32'd0, 32'd4);
            chk($sformatf("arst_idle%0d_halt", k), a_halt, 0);
            chk($sformatf("arst_idle%0d_pulse", k), a_pulse, 0);
        end
        step(1'b1, EBRK, 32'h8000_0060, 32'd7);
        step(1'b0, 32'd0, 32'd0, 32'd7);
        chk("post_nohalt", a_halt, 0);
        step(1'b0, 32'd0, 32'd0, 32'd7);
        chk("post_halt", a_halt, 1);
        chk("post_pulse", a_pulse, 1);
        chk("post_reason", a_reason, 1);
        chk("post_code", a_code, 7);
        chk("post_tpc", a_tpc, 32'h8000_0060);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
